mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter NBITS, default 32, operand and result width in bits; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port istream_val  input  1  request valid.
REQ-005 SHALL have port istream_rdy  output  1  unit ready to accept a request.
REQ-006 SHALL have port istream_msg  input  64  operands {a[63:32], b[31:0]}.
REQ-007 SHALL have port ostream_val  output  1  result valid.
REQ-008 SHALL have port ostream_rdy  input  1  consumer ready for the result.
REQ-009 SHALL have port ostream_msg  output  32  result, low 32 bits of a*b.

Function
REQ-010 SHALL implement three states: IDLE, CALC, DONE.
REQ-011 In IDLE, SHALL drive istream_rdy=1 and ostream_val=0.
REQ-012 In CALC and DONE, SHALL drive istream_rdy=0.
REQ-013 A request transfer SHALL occur only when istream_val=1 and istream_rdy=1 on a rising edge.
REQ-014 On a request transfer, SHALL latch A=a, B=b, result=0 and counter=0, then enter CALC.
REQ-015 In each CALC cycle, SHALL add A to result if B[0]=1, then shift A left by 1, shift B right logically by 1, and increment the counter; all arithmetic wraps modulo 2^32.
REQ-016 SHALL spend exactly 32 cycles in CALC, then enter DONE.
REQ-017 Latency: for a request accepted in cycle N, SHALL assert ostream_val in cycle N+33, independent of operand values.
REQ-018 In DONE, SHALL drive ostream_val=1 and ostream_msg=result.
REQ-019 In DONE, ostream_msg SHALL stay stable until ostream_val=1 and ostream_rdy=1 on a rising edge; the unit then returns to IDLE.
REQ-020 Result SHALL equal the low 32 bits of the product, which is identical for signed and unsigned two's-complement operands.
REQ-021 istream_msg SHALL be ignored outside IDLE; ostream_rdy SHALL be ignored outside DONE.
REQ-022 There SHALL be no same-cycle overlap of an output handshake and a new request acceptance; the earliest new accept is the cycle after the output handshake.
REQ-023 ostream_msg SHALL be don't-care when ostream_val=0, but SHALL never be X in DONE.

Reset
REQ-024 While rst=1 at a rising edge, SHALL enter IDLE and clear counter and result to 0.
REQ-025 After reset, outputs SHALL be istream_rdy=1, ostream_val=0, ostream_msg=0.
REQ-026 Reset asserted during CALC or DONE SHALL abandon the operation with no result emitted.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028 A shared package mul_iter_pkg SHALL hold the state enum (IDLE, CALC, DONE) and constants NBITS=32 and CNT_MAX=31.
REQ-029 SHALL be split into a control FSM sub-module mul_iter_ctrl (state, counter, handshake signals) and top-level datapath registers A, B and result.
REQ-030 All registers SHALL be clocked by clk only, with no latches and no combinational path from ostream_rdy to istream_rdy.

Verification
REQ-031 Basic: a=3, b=4, ostream_rdy=1 -> ostream_msg=0x0000000C, with ostream_val high exactly 33 cycles after accept.
REQ-032 Negative and large: 0xFFFFFFFE*0x00000003 -> 0xFFFFFFFA; 0x7FFFFFFF*0x7FFFFFFF -> 0x00000001; 0x00010000*0x00010000 -> 0x00000000.
REQ-033 Zeros and ones: 0x00000000*0xDEADBEEF -> 0x00000000; 0x00000001*0xDEADBEEF -> 0xDEADBEEF, each at the same latency.
REQ-034 Backpressure: ostream_rdy=0 for 5 cycles in DONE -> ostream_msg stable and istream_rdy=0 throughout; with istream_val held high, the next request is accepted the cycle after the output handshake.
REQ-035 Reset mid-op: rst=1 for one cycle at CALC cycle 10 -> next cycle istream_rdy=1 and ostream_val=0; no stale result appears; the following request 5*7 -> 0x00000023.

Source files
------------

// File: rtl/mul_iter_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Imported by the control FSM and the handshake interface.
package mul_iter_pkg;

    localparam int NBITS   = 32;
    localparam int CNT_MAX = 31;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/mul_iter_if.sv
// Request/response valid-ready bundle for mul_iter.
// The master drives requests and consumes results; the slave is the unit.
interface mul_iter_if #(
    parameter int NBITS = mul_iter_pkg::NBITS
);

    logic               istream_val;
    logic               istream_rdy;
    logic [2*NBITS-1:0] istream_msg;
    logic               ostream_val;
    logic               ostream_rdy;
    logic [NBITS-1:0]   ostream_msg;

    modport master (
        output istream_val,
        output istream_msg,
        output ostream_rdy,
        input  istream_rdy,
        input  ostream_val,
        input  ostream_msg
    );

    modport slave (
        input  istream_val,
        input  istream_msg,
        input  ostream_rdy,
        output istream_rdy,
        output ostream_val,
        output ostream_msg
    );

endinterface

// File: rtl/mul_iter_ctrl.sv
// Control FSM for mul_iter: IDLE/CALC/DONE sequencing, step counter,
// and handshake outputs. Datapath strobes are load and step.
module mul_iter_ctrl
    import mul_iter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_val,
    input  logic out_rdy,
    output logic in_rdy,
    output logic out_val,
    output logic load,
    output logic step
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last = (cnt == CNT_W'(CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter wraps back to zero on the final CALC step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_val)  state_nxt = CALC;
            CALC: if (last)    state_nxt = DONE;
            DONE: if (out_rdy) state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state == IDLE);
        out_val = (state == DONE);
        step    = (state == CALC);
        load    = in_rdy & in_val;
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative 32-cycle shift-add multiplier, low NBITS of a*b.
// Datapath registers live here; sequencing is in mul_iter_ctrl.
module mul_iter #(
    parameter int NBITS = mul_iter_pkg::NBITS
) (
    input  logic        clk,
    input  logic        rst,
    mul_iter_if.slave   io
);

    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] res_q;
    logic             load;
    logic             step;

    mul_iter_ctrl u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .in_val  (io.istream_val),
        .out_rdy (io.ostream_rdy),
        .in_rdy  (io.istream_rdy),
        .out_val (io.ostream_val),
        .load    (load),
        .step    (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else if (load) begin
            a_q   <= io.istream_msg[2*NBITS-1:NBITS];
            b_q   <= io.istream_msg[NBITS-1:0];
            res_q <= '0;
        end else if (step) begin
            if (b_q[0]) begin
                res_q <= res_q + a_q;
            end
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
        end
    end

    assign io.ostream_msg = res_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: cycle model plus directed and
// randomized operations.
module tb_mul_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mul_iter_if #(.NBITS(32)) io ();

    mul_iter #(.NBITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Model: a pending product becomes visible 33 cycles after accept
    // and stays until the consumer takes it.
    bit          m_on   = 1'b0;
    bit          m_pend = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_exp  = '0;

    always @(posedge clk) begin
        logic [31:0] ta;
        logic [31:0] tb;
        if (rst) begin
            m_pend = 1'b0;
            m_on   = 1'b1;
        end else if (m_pend) begin
            if (m_wait > 0) m_wait--;
            else if (io.ostream_rdy) m_pend = 1'b0;
        end else if (io.istream_val) begin
            ta     = io.istream_msg[63:32];
            tb     = io.istream_msg[31:0];
            m_exp  = ta * tb;
            m_pend = 1'b1;
            m_wait = 32;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("istream_rdy", 32'(io.istream_rdy), 32'(!m_pend));
            chk("ostream_val", 32'(io.ostream_val),
                32'(m_pend && m_wait == 0));
            if (m_pend && m_wait == 0)
                chk("ostream_msg", io.ostream_msg, m_exp);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk);
        #1;
        io.istream_val = 1'b1;
        io.istream_msg = {a, b};
        n = 0;
        @(negedge clk);
        while (!io.istream_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!io.istream_rdy) timeout("accept");
        @(posedge clk);
        #1;
        io.istream_val = 1'b0;
    endtask

    task automatic recv(input int hold, input int start,
                        output logic [31:0] got, output int lat);
        lat = start;
        do begin
            @(negedge clk);
            lat++;
        end while (!io.ostream_val && lat < 100);
        got = io.ostream_msg;
        if (!io.ostream_val) begin
            timeout("result");
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_msg", io.ostream_msg, got);
        end
        io.ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        io.ostream_rdy = 1'b0;
    endtask

    logic [31:0] da [6] = '{32'h3, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
                            32'h0001_0000, 32'h0, 32'h1};
    logic [31:0] db [6] = '{32'h4, 32'h3, 32'h7FFF_FFFF,
                            32'h0001_0000, 32'hDEAD_BEEF,
                            32'hDEAD_BEEF};
    logic [31:0] de [6] = '{32'hC, 32'hFFFF_FFFA, 32'h1,
                            32'h0, 32'h0, 32'hDEAD_BEEF};

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        int          lat;

        io.istream_val = 1'b0;
        io.istream_msg = '0;
        io.ostream_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_irdy", 32'(io.istream_rdy), 32'd1);
        chk("rst_oval", 32'(io.ostream_val), 32'd0);
        chk("rst_omsg", io.ostream_msg, 32'd0);

        for (int i = 0; i < 6; i++) begin
            send(da[i], db[i]);
            recv(0, 0, got, lat);
            chk("dir_msg", got, de[i]);
            chk("dir_model", m_exp, de[i]);
            chk("dir_lat", 32'(lat), 32'd33);
        end

        // Backpressure with the next request already waiting.
        send(32'd9, 32'd11);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!io.ostream_val && lat < 100);
        chk("bp_lat", 32'(lat), 32'd33);
        got = io.ostream_msg;
        chk("bp_msg", got, 32'd99);
        io.istream_val = 1'b1;
        io.istream_msg = {32'd6, 32'd7};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", io.ostream_msg, 32'd99);
            chk("bp_irdy", 32'(io.istream_rdy), 32'd0);
        end
        io.ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        io.ostream_rdy = 1'b0;
        @(negedge clk);
        chk("next_rdy", 32'(io.istream_rdy), 32'd1);
        @(posedge clk);
        #1;
        io.istream_val = 1'b0;
        @(negedge clk);
        chk("next_taken", 32'(io.istream_rdy), 32'd0);
        recv(2, 1, got, lat);
        chk("next_msg", got, 32'd42);
        chk("next_lat", 32'(lat), 32'd33);

        // Reset in the middle of CALC abandons the operation.
        send(32'h1234, 32'h5678);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_irdy", 32'(io.istream_rdy), 32'd1);
        chk("mid_oval", 32'(io.ostream_val), 32'd0);
        repeat (40) @(negedge clk);
        send(32'd5, 32'd7);
        recv(0, 0, got, lat);
        chk("post_msg", got, 32'h23);
        chk("post_lat", 32'(lat), 32'd33);

        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 1) b = 32'hFFFF_FFFF;
            if (i % 7 == 2) a = 32'h8000_0000;
            want = a * b;
            send(a, b);
            recv($urandom_range(0, 3), 0, got, lat);
            chk("rnd_msg", got, want);
            chk("rnd_lat", 32'(lat), 32'd33);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
